// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: takes a word over a valid/ready load
// handshake and shifts it out one bit per clock, back-to-back capable.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rs,
    input  logic [WIDTH-1:0] pi,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             lastBit;
    logic             accept;
    logic [WIDTH-1:0] shifted;

    assign lastBit = (state_q == SHIFT) && (cnt_q == LAST);
    assign accept  = ld_valid && ld_ready;

    always_ff @(posedge clk) begin
        if (rs) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Zero-fill on every shift so the register drains to all-zero at the end
    // of a word, which keeps sout low while idle.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = pi;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    // Last bit is on the line: a load here continues with no gap.
                    done_d = 1'b1;
                    if (accept) begin
                        shreg_d = pi;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        sout_valid = (state_q == SHIFT);
        busy       = (state_q == SHIFT);
        done       = done_q;
        ld_ready   = !rs && ((state_q == IDLE) || lastBit);
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Self-checking bench for piso_shift_tx: an LSB-first and an MSB-first
// instance compared every cycle against a queue-of-bits model, plus a SIPO loopback.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       rs;
    logic [7:0] piV       [2];
    logic       ldValid   [2];
    logic       ldReady   [2];
    logic       sout      [2];
    logic       soutValid [2];
    logic       busy      [2];
    logic       done      [2];

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) uLsb (
        .clk(clk), .rs(rs), .pi(piV[0]), .ld_valid(ldValid[0]), .ld_ready(ldReady[0]),
        .sout(sout[0]), .sout_valid(soutValid[0]), .busy(busy[0]), .done(done[0])
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) uMsb (
        .clk(clk), .rs(rs), .pi(piV[1]), .ld_valid(ldValid[1]), .ld_ready(ldReady[1]),
        .sout(sout[1]), .sout_valid(soutValid[1]), .busy(busy[1]), .done(done[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: each accepted word becomes a queue of bits in line order; the
    // head of the queue is what must be on sout this cycle.
    bit         bitQ [2][$];
    logic [7:0] wordQ[$];
    logic       expDone[2];
    bit         armed = 1'b0;
    bit         mRdy;
    logic [7:0] sipo;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rs) begin
                bitQ[k].delete();
                expDone[k] = 1'b0;
            end else begin
                mRdy       = (bitQ[k].size() <= 1);
                expDone[k] = (bitQ[k].size() == 1);
                if (bitQ[k].size() > 0) void'(bitQ[k].pop_front());
                if (ldValid[k] && mRdy) begin
                    for (int i = 0; i < 8; i++) begin
                        bitQ[k].push_back((k == 0) ? piV[k][i] : piV[k][7-i]);
                    end
                    if (k == 0) wordQ.push_back(piV[k]);
                end
            end
        end
        if (rs) begin
            wordQ.delete();
            armed = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rs) sipo <= 8'h00;
        else if (soutValid[0]) sipo <= {sout[0], sipo[7:1]};
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("sout%0d", k), 32'(sout[k]),
                            32'((bitQ[k].size() > 0) ? bitQ[k][0] : 1'b0));
                checkOutput($sformatf("soutValid%0d", k), 32'(soutValid[k]), 32'(bitQ[k].size() > 0));
                checkOutput($sformatf("busy%0d", k), 32'(busy[k]), 32'(bitQ[k].size() > 0));
                checkOutput($sformatf("done%0d", k), 32'(done[k]), 32'(expDone[k]));
                checkOutput($sformatf("ldReady%0d", k), 32'(ldReady[k]),
                            32'(!rs && (bitQ[k].size() <= 1)));
            end
            if (expDone[0]) begin
                if (wordQ.size() == 0) checkOutput("loopbackQueue", 32'(wordQ.size()), 32'd1);
                else                   checkOutput("loopbackWord", 32'(sipo), 32'(wordQ.pop_front()));
            end
        end
    end

    logic [15:0] cap[2];
    int          capCnt[2];
    int          doneCnt[2];

    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                if (soutValid[k] === 1'b1) begin
                    cap[k] = {cap[k][14:0], sout[k]};
                    capCnt[k]++;
                end
                if (done[k] === 1'b1) doneCnt[k]++;
            end
        end
    end

    task automatic clearCapture();
        for (int k = 0; k < 2; k++) begin
            cap[k]     = 16'h0000;
            capCnt[k]  = 0;
            doneCnt[k] = 0;
        end
    endtask

    task automatic applyStimulus(input int k, input logic valid, input logic [7:0] word, input logic rsVal);
        @(negedge clk);
        #1;
        rs          = rsVal;
        ldValid[k]  = valid;
        piV[k]      = word;
        ldValid[1-k] = 1'b0;
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) applyStimulus(k, 1'b0, 8'($urandom), 1'b0);
    endtask

    // Holds the request until the transmitter takes it at the next edge.
    task automatic loadWord(input int k, input logic [7:0] word);
        bit taken = 1'b0;
        applyStimulus(k, 1'b1, word, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (ldReady[k] === 1'b1) begin
                taken = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (!taken) checkOutput("loadTimeout", 32'(taken), 32'd1);
    endtask

    initial begin
        logic [7:0] word;
        rs         = 1'b1;
        ldValid[0] = 1'b1;
        ldValid[1] = 1'b1;
        piV[0]     = 8'h5A;
        piV[1]     = 8'hC3;
        clearCapture();

        repeat (2) @(negedge clk);
        checkOutput("rstReady", 32'(ldReady[0]), 32'd0);
        checkOutput("rstBusy", 32'(busy[0]), 32'd0);
        #1;
        rs         = 1'b0;
        ldValid[0] = 1'b0;
        ldValid[1] = 1'b0;
        #1;
        checkOutput("postRstReady", 32'(ldReady[0]), 32'd1);
        checkOutput("postRstDone", 32'(done[0]), 32'd0);

        clearCapture();
        loadWord(0, 8'hA5);
        idle(0, 11);
        checkOutput("a5Bits", 32'(cap[0][7:0]), 32'hA5);
        checkOutput("a5Count", 32'(capCnt[0]), 32'd8);
        checkOutput("a5Done", 32'(doneCnt[0]), 32'd1);

        clearCapture();
        loadWord(0, 8'h0F);
        loadWord(0, 8'hF0);
        idle(0, 12);
        checkOutput("b2bBits", 32'(cap[0]), 32'hF00F);
        checkOutput("b2bCount", 32'(capCnt[0]), 32'd16);
        checkOutput("b2bDone", 32'(doneCnt[0]), 32'd2);

        clearCapture();
        loadWord(0, 8'h81);
        idle(0, 2);
        applyStimulus(0, 1'b1, 8'hFF, 1'b0);
        idle(0, 10);
        checkOutput("ignoreBits", 32'(cap[0][7:0]), 32'h81);
        checkOutput("ignoreCount", 32'(capCnt[0]), 32'd8);

        clearCapture();
        loadWord(0, 8'hFF);
        idle(0, 3);
        applyStimulus(0, 1'b0, 8'($urandom), 1'b1);
        applyStimulus(0, 1'b0, 8'($urandom), 1'b0);
        checkOutput("abortBusy", 32'(busy[0]), 32'd0);
        checkOutput("abortSout", 32'(sout[0]), 32'd0);
        idle(0, 3);
        checkOutput("abortCount", 32'(capCnt[0]), 32'd4);
        checkOutput("abortDone", 32'(doneCnt[0]), 32'd0);
        clearCapture();
        loadWord(0, 8'h3C);
        idle(0, 10);
        checkOutput("afterAbortBits", 32'(cap[0][7:0]), 32'h3C);

        clearCapture();
        loadWord(1, 8'hA5);
        idle(1, 10);
        checkOutput("msbA5Bits", 32'(cap[1][7:0]), 32'hA5);
        clearCapture();
        loadWord(1, 8'h80);
        idle(1, 10);
        checkOutput("msb80Bits", 32'(cap[1][7:0]), 32'h80);
        checkOutput("msb80Count", 32'(capCnt[1]), 32'd8);

        // Random traffic with gaps of zero to three cycles and stray requests.
        repeat (40) begin
            word = 8'($urandom);
            loadWord(0, word);
            repeat ($urandom_range(0, 3)) begin
                applyStimulus(0, ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0);
            end
        end
        idle(0, 20);
        checkOutput("loopDrain", 32'(wordQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
